// File: rtl/axi_mmu_pkg.sv
// axi_mmu_pkg: AXI burst encodings, 4 KB page shift and the bit layout
// of one buffered address-channel entry (fixed fields low, then user/addr/id).
package axi_mmu_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    localparam int PAGE_SHIFT = 12;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int PROT_W  = 3;
    localparam int CACHE_W = 4;

    localparam int XERR_BIT  = 0;
    localparam int LOCK_BIT  = 1;
    localparam int CACHE_LSB = 2;
    localparam int PROT_LSB  = CACHE_LSB + CACHE_W;
    localparam int BURST_LSB = PROT_LSB + PROT_W;
    localparam int SIZE_LSB  = BURST_LSB + BURST_W;
    localparam int LEN_LSB   = SIZE_LSB + SIZE_W;
    localparam int FIX_W     = LEN_LSB + LEN_W;

    function automatic int entry_w(int id_w, int addr_w, int user_w);
        return id_w + addr_w + user_w + FIX_W;
    endfunction

endpackage

// File: rtl/axi_addr_ch_buf_if.sv
// axi_addr_ch_buf_if: upstream (in_*) and downstream (out_*) AR/AW request
// channels of the buffer; slave = buffer side, master = environment side.
interface axi_addr_ch_buf_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int USER_W = 2
);
    import axi_mmu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [ID_W-1:0]     in_id;
    logic [ADDR_W-1:0]   in_addr;
    logic [LEN_W-1:0]    in_len;
    logic [SIZE_W-1:0]   in_size;
    logic [BURST_W-1:0]  in_burst;
    logic [PROT_W-1:0]   in_prot;
    logic [CACHE_W-1:0]  in_cache;
    logic [USER_W-1:0]   in_user;
    logic                in_lock;

    logic                out_valid;
    logic                out_ready;
    logic [ID_W-1:0]     out_id;
    logic [ADDR_W-1:0]   out_addr;
    logic [LEN_W-1:0]    out_len;
    logic [SIZE_W-1:0]   out_size;
    logic [BURST_W-1:0]  out_burst;
    logic [PROT_W-1:0]   out_prot;
    logic [CACHE_W-1:0]  out_cache;
    logic [USER_W-1:0]   out_user;
    logic                out_lock;
    logic                out_xerr;

    modport slave (
        input  in_valid, in_id, in_addr, in_len, in_size,
        input  in_burst, in_prot, in_cache, in_user, in_lock,
        output in_ready,
        output out_valid, out_id, out_addr, out_len, out_size,
        output out_burst, out_prot, out_cache, out_user, out_lock,
        output out_xerr,
        input  out_ready
    );

    modport master (
        output in_valid, in_id, in_addr, in_len, in_size,
        output in_burst, in_prot, in_cache, in_user, in_lock,
        input  in_ready,
        input  out_valid, out_id, out_addr, out_len, out_size,
        input  out_burst, out_prot, out_cache, out_user, out_lock,
        input  out_xerr,
        output out_ready
    );

endinterface

// File: rtl/synch_fifo.sv
// synch_fifo: single-clock FIFO storage with combinational head read.
// Ports: rx_clk, reset_ (sync, low), wr_en/wr_data, rd_en/rd_data, empty.
module synch_fifo #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic          rx_clk,
    input  logic          reset_,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge rx_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/axi_addr_ch_buf.sv
// axi_addr_ch_buf: FIFO buffer for AXI AR/AW requests with one-cycle
// fall-through, 4 KB crossing flag (out_xerr) computed at push time.
// Ports: rx_clk, reset_ (sync, low), bus (in_*/out_* channels),
//        count (stored entries), almost_full (count >= AFULL_TH).
module axi_addr_ch_buf
    import axi_mmu_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int USER_W   = 2,
    parameter int DEPTH    = 64,
    parameter int AFULL_TH = DEPTH - 4
) (
    input  logic                   rx_clk,
    input  logic                   reset_,
    axi_addr_ch_buf_if.slave       bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int DW       = entry_w(ID_W, ADDR_W, USER_W);
    localparam int USER_LSB = FIX_W;
    localparam int ADDR_LSB = USER_LSB + USER_W;
    localparam int ID_LSB   = ADDR_LSB + ADDR_W;
    localparam int AW1      = ADDR_W + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    logic [AW1-1:0] span;
    logic [AW1-1:0] last;
    logic           in_xerr;
    logic           unused_last;

    logic [DW-1:0]  in_entry;
    logic [DW-1:0]  fifo_dout;
    logic [DW-1:0]  stage_q;
    logic           out_valid_q;
    logic           in_ready_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    logic           push;
    logic           pop;
    logic           stage_free;
    logic           fifo_empty;
    logic           load_fifo;
    logic           load_in;
    logic           fifo_wr;

    // Last byte of the burst, one bit wider than the address so the
    // carry out of the top page is kept rather than wrapped away.
    assign span = (AW1'(bus.in_len) + AW1'(1)) << bus.in_size;
    assign last = {1'b0, bus.in_addr} + span - AW1'(1);

    assign in_xerr = (bus.in_burst == BURST_INCR) &&
                     (bus.in_addr[ADDR_W-1:PAGE_SHIFT] !=
                      last[ADDR_W-1:PAGE_SHIFT]);

    assign unused_last = ^{last[AW1-1], last[PAGE_SHIFT-1:0]};

    always_comb begin
        in_entry = '0;
        in_entry[XERR_BIT]               = in_xerr;
        in_entry[LOCK_BIT]               = bus.in_lock;
        in_entry[CACHE_LSB +: CACHE_W]   = bus.in_cache;
        in_entry[PROT_LSB +: PROT_W]     = bus.in_prot;
        in_entry[BURST_LSB +: BURST_W]   = bus.in_burst;
        in_entry[SIZE_LSB +: SIZE_W]     = bus.in_size;
        in_entry[LEN_LSB +: LEN_W]       = bus.in_len;
        in_entry[USER_LSB +: USER_W]     = bus.in_user;
        in_entry[ADDR_LSB +: ADDR_W]     = bus.in_addr;
        in_entry[ID_LSB +: ID_W]         = bus.in_id;
    end

    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    // The stage always holds the oldest entry, so the FIFO is only
    // non-empty behind a valid stage. An incoming request skips the
    // FIFO when the stage is free and nothing older is waiting.
    assign stage_free = !out_valid_q || pop;
    assign load_fifo  = stage_free && !fifo_empty;
    assign load_in    = stage_free && fifo_empty && push;
    assign fifo_wr    = push && !load_in;

    synch_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (DEPTH)
    ) u_fifo (
        .rx_clk  (rx_clk),
        .reset_  (reset_),
        .wr_en   (fifo_wr),
        .wr_data (in_entry),
        .rd_en   (load_fifo),
        .rd_data (fifo_dout),
        .empty   (fifo_empty)
    );

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (!reset_) begin
            stage_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= (count_d < DEPTH_C);
            if (load_fifo) begin
                stage_q     <= fifo_dout;
                out_valid_q <= 1'b1;
            end else if (load_in) begin
                stage_q     <= in_entry;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_xerr  = stage_q[XERR_BIT];
    assign bus.out_lock  = stage_q[LOCK_BIT];
    assign bus.out_cache = stage_q[CACHE_LSB +: CACHE_W];
    assign bus.out_prot  = stage_q[PROT_LSB +: PROT_W];
    assign bus.out_burst = stage_q[BURST_LSB +: BURST_W];
    assign bus.out_size  = stage_q[SIZE_LSB +: SIZE_W];
    assign bus.out_len   = stage_q[LEN_LSB +: LEN_W];
    assign bus.out_user  = stage_q[USER_LSB +: USER_W];
    assign bus.out_addr  = stage_q[ADDR_LSB +: ADDR_W];
    assign bus.out_id    = stage_q[ID_LSB +: ID_W];

    assign count       = count_q;
    assign almost_full = (count_q >= AFULL_C);

    a_count_max: assert property (
        @(posedge rx_clk) disable iff (!reset_) count_q <= DEPTH_C
    );

    a_no_push_full: assert property (
        @(posedge rx_clk) disable iff (!reset_)
        (count_q == DEPTH_C) |-> !push
    );

endmodule

// File: tb/tb_axi_addr_ch_buf.sv
// tb_axi_addr_ch_buf: scoreboard bench for axi_addr_ch_buf (DEPTH=8).
// Inputs change 1ns after rising edges; the monitor samples on falling edges.
module tb_axi_addr_ch_buf;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  prot;
        logic [3:0]  cache;
        logic [1:0]  user;
        logic        lock;
        logic        xerr;
    } req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        exp;
    } xcase_t;

    logic       rx_clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] count;
    logic       almost_full;

    int   total = 0;
    int   bad   = 0;
    req_t sb[$];
    req_t prev_out;
    logic prev_hold = 1'b0;

    axi_addr_ch_buf_if #(.ID_W(4), .ADDR_W(32), .USER_W(2)) bus ();

    axi_addr_ch_buf #(
        .ID_W     (4),
        .ADDR_W   (32),
        .USER_W   (2),
        .DEPTH    (8),
        .AFULL_TH (4)
    ) dut (
        .rx_clk      (rx_clk),
        .reset_      (reset_),
        .bus         (bus),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 rx_clk = ~rx_clk;

    function automatic logic model_xerr(input logic [31:0] a,
                                        input logic [7:0]  l,
                                        input logic [2:0]  s,
                                        input logic [1:0]  b);
        logic [63:0] e;
        e = 64'(a) + ((64'(l) + 64'd1) << s) - 64'd1;
        return (b == 2'b01) && (e[31:12] != a[31:12]);
    endfunction

    function automatic req_t in_req();
        req_t r;
        r.id    = bus.in_id;
        r.addr  = bus.in_addr;
        r.len   = bus.in_len;
        r.size  = bus.in_size;
        r.burst = bus.in_burst;
        r.prot  = bus.in_prot;
        r.cache = bus.in_cache;
        r.user  = bus.in_user;
        r.lock  = bus.in_lock;
        r.xerr  = model_xerr(bus.in_addr, bus.in_len, bus.in_size, bus.in_burst);
        return r;
    endfunction

    function automatic req_t out_req();
        req_t r;
        r.id    = bus.out_id;
        r.addr  = bus.out_addr;
        r.len   = bus.out_len;
        r.size  = bus.out_size;
        r.burst = bus.out_burst;
        r.prot  = bus.out_prot;
        r.cache = bus.out_cache;
        r.user  = bus.out_user;
        r.lock  = bus.out_lock;
        r.xerr  = bus.out_xerr;
        return r;
    endfunction

    always @(negedge rx_clk) begin
        req_t got;
        req_t exp;
        if (reset_) begin
            if (prev_hold) begin
                total++;
                got = out_req();
                if (bus.out_valid !== 1'b1 || got !== prev_out) begin
                    bad++;
                    $display("FAIL hold: got v=%0b %h required v=1 %h",
                             bus.out_valid, got, prev_out);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                got = out_req();
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got %h required nothing", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL sb_entry: got %h required %h", got, exp);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(in_req());
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_out  = out_req();
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0]  id,
                             input logic [31:0] addr,
                             input logic [7:0]  len,
                             input logic [2:0]  size,
                             input logic [1:0]  burst);
        bus.in_valid = 1'b1;
        bus.in_id    = id;
        bus.in_addr  = addr;
        bus.in_len   = len;
        bus.in_size  = size;
        bus.in_burst = burst;
        bus.in_prot  = id[2:0];
        bus.in_cache = ~id;
        bus.in_user  = id[1:0];
        bus.in_lock  = id[0];
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        bus.out_ready = 1'b1;
        drive_req(4'd9, 32'h0000_2000, 8'd1, 3'd2, 2'b01);
        repeat (3) tick();
        total++;
        if (count !== 4'd0) begin
            bad++; $display("FAIL rst_count: got %0d required 0", count);
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_hs: got ov=%0b ir=%0b required 0 0",
                     bus.out_valid, bus.in_ready);
        end
        total++;
        if (almost_full !== 1'b0) begin
            bad++; $display("FAIL rst_af: got %0b required 0", almost_full);
        end
        total++;
        if (out_req() !== '0) begin
            bad++; $display("FAIL rst_fields: got %h required 0", out_req());
        end
        bus.in_valid = 1'b0;
        reset_ = 1'b1;
        tick();
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_release: got ir=%0b ov=%0b required 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b0;
        drive_req(4'd5, 32'h0000_1000, 8'd3, 3'd2, 2'b01);
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 4'd5 ||
            bus.out_addr !== 32'h0000_1000 || bus.out_len !== 8'd3 ||
            bus.out_size !== 3'd2 || bus.out_burst !== 2'b01) begin
            bad++;
            $display("FAIL single_out: got v=%0b %h required v=1 id5 a1000",
                     bus.out_valid, out_req());
        end
        total++;
        if (bus.out_xerr !== 1'b0 || count !== 4'd1) begin
            bad++;
            $display("FAIL single_cnt: got xerr=%0b cnt=%0d required 0 1",
                     bus.out_xerr, count);
        end
        tick();
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (count !== 4'd0 || bus.out_valid !== 1'b0 ||
            bus.out_addr !== 32'h0000_1000) begin
            bad++;
            $display("FAIL single_pop: got cnt=%0d v=%0b a=%h required 0 0 1000",
                     count, bus.out_valid, bus.out_addr);
        end
    endtask

    task automatic test_xerr();
        xcase_t xt [10];
        xt = '{
            '{32'h0000_0FF0, 8'd7,   3'd2, 2'b01, 1'b1},
            '{32'h0000_0FF0, 8'd7,   3'd2, 2'b10, 1'b0},
            '{32'h0000_0FC0, 8'd15,  3'd2, 2'b01, 1'b0},
            '{32'h0000_0FC0, 8'd16,  3'd2, 2'b01, 1'b1},
            '{32'h0000_0FFF, 8'd0,   3'd0, 2'b01, 1'b0},
            '{32'hFFFF_FFF0, 8'd7,   3'd2, 2'b01, 1'b1},
            '{32'h0000_0FF0, 8'd7,   3'd2, 2'b00, 1'b0},
            '{32'h0000_0FF0, 8'd7,   3'd2, 2'b11, 1'b0},
            '{32'h0000_0000, 8'd255, 3'd7, 2'b01, 1'b1},
            '{32'h0000_1000, 8'd255, 3'd4, 2'b01, 1'b0}
        };
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_req(4'(i), xt[i].addr, xt[i].len, xt[i].size, xt[i].burst);
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_xerr !== xt[i].exp ||
                bus.out_addr !== xt[i].addr || count !== 4'd1) begin
                bad++;
                $display("FAIL xerr_%0d: got v=%0b x=%0b a=%h c=%0d required 1 %0b %h 1",
                         i, bus.out_valid, bus.out_xerr, bus.out_addr, count,
                         xt[i].exp, xt[i].addr);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        total++;
        if (count !== 4'd0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL xerr_drain: got c=%0d v=%0b required 0 0",
                     count, bus.out_valid);
        end
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++; $display("FAIL full_rdy_%0d: got 0 required 1", k);
            end
            drive_req(4'(k - 1), 32'h0000_4000 + 32'(k * 64), 8'd0, 3'd3, 2'b01);
            tick();
            total++;
            if (count !== 4'(k) || almost_full !== (k >= 4)) begin
                bad++;
                $display("FAIL full_cnt_%0d: got c=%0d af=%0b required %0d %0b",
                         k, count, almost_full, k, (k >= 4));
            end
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL full_ready: got 1 required 0");
        end
        drive_req(4'hF, 32'h0000_9000, 8'd0, 3'd0, 2'b00);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || count !== 4'd7 || almost_full !== 1'b1) begin
            bad++;
            $display("FAIL full_pop: got ir=%0b c=%0d af=%0b required 1 7 1",
                     bus.in_ready, count, almost_full);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && count != 4'd0; i++) tick();
        total++;
        if (count !== 4'd0 || bus.out_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL full_drain: got c=%0d v=%0b sb=%0d required 0 0 0",
                     count, bus.out_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive_req(4'(i), 32'h0001_0000 + 32'(i * 16), 8'd1, 3'd1, 2'b01);
            tick();
            total++;
            if (count !== 4'd1 || bus.out_valid !== 1'b1 || bus.out_id !== 4'(i) ||
                bus.out_addr !== 32'h0001_0000 + 32'(i * 16)) begin
                bad++;
                $display("FAIL b2b_%0d: got c=%0d v=%0b id=%0d a=%h required 1 1 %0d",
                         i, count, bus.out_valid, bus.out_id, bus.out_addr, i % 16);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        total++;
        if (count !== 4'd0) begin
            bad++; $display("FAIL b2b_end: got %0d required 0", count);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        for (int c = 0; c < 300; c++) begin
            if (sent < 120 && $urandom_range(0, 1) == 1) begin
                drive_req(4'(sent), $urandom(), 8'($urandom_range(0, 255)),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
                bus.in_prot  = 3'($urandom_range(0, 7));
                bus.in_cache = 4'($urandom_range(0, 15));
                bus.in_user  = 2'($urandom_range(0, 3));
                bus.in_lock  = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) == 0);
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            total++;
            if (count !== 4'(sb.size())) begin
                bad++;
                $display("FAIL stall_cnt_%0d: got %0d required %0d",
                         c, count, sb.size());
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && count != 4'd0; i++) tick();
        total++;
        if (count !== 4'd0 || sb.size() != 0) begin
            bad++;
            $display("FAIL stall_drain: got c=%0d sb=%0d required 0 0",
                     count, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_req(4'(k), 32'h0000_5000 + 32'(k * 8), 8'd0, 3'd2, 2'b01);
            tick();
        end
        bus.in_valid = 1'b0;
        total++;
        if (count !== 4'd5) begin
            bad++; $display("FAIL mid_fill: got %0d required 5", count);
        end
        reset_ = 1'b0;
        drive_req(4'hA, 32'h0000_6000, 8'd0, 3'd2, 2'b01);
        bus.out_ready = 1'b1;
        sb.delete();
        tick();
        total++;
        if (count !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst: got c=%0d v=%0b ir=%0b required 0 0 0",
                     count, bus.out_valid, bus.in_ready);
        end
        reset_ = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        total++;
        if (bus.in_ready !== 1'b1 || count !== 4'd0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_release: got ir=%0b c=%0d v=%0b required 1 0 0",
                     bus.in_ready, count, bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_id     = '0;
        bus.in_addr   = '0;
        bus.in_len    = '0;
        bus.in_size   = '0;
        bus.in_burst  = '0;
        bus.in_prot   = '0;
        bus.in_cache  = '0;
        bus.in_user   = '0;
        bus.in_lock   = 1'b0;
        test_reset();
        test_single();
        test_xerr();
        test_full();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_left: got %0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
